// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: word width, reset/step
// defaults and the fetch FSM state encoding.
// FETCH_TIMEOUT_EN adds the FAULT state used by the memory-timeout watchdog.
package instruction_fetch_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_PC_STEP  = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2
`ifdef FETCH_TIMEOUT_EN
    ,
    FAULT = 2'd3
`endif
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_watchdog.sv
// Memory-request watchdog for the fetch unit. Counts enabled cycles from 0 and
// flags expiry in the cycle that would make the count reach TIMEOUT_CYCLES.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic nRst,
  input  logic cnt_en_i,
  input  logic cnt_clr_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so a restarted request always counts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = cnt_en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one memory read per fetch_start, latches the
// returned word into ir and supports branch redirects, including squashing a
// request already in flight. FETCH_TIMEOUT_EN adds a sticky memory-timeout fault.
//
// state | meaning
// IDLE  | waiting for fetch_start
// REQ   | mem_req high at fetch_addr, waiting for mem_ack
// DONE  | ir just updated, ir_valid pulse
// FAULT | memory timeout, left only by reset (FETCH_TIMEOUT_EN only)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP        = DEFAULT_PC_STEP,
  parameter int unsigned       TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              nRst,
  input  logic              fetch_start,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ir,
  output logic              ir_valid,
  output logic [WORD_W-1:0] pc,
  output logic              busy,
  output logic              fetch_fault
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] target_q, target_d;
  logic              squash_q, squash_d;
  logic              wd_expired;

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .nRst      (nRst),
    .cnt_en_i  (state_q == REQ),
    .cnt_clr_i ((state_q != REQ) || mem_ack),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state and datapath updates; a redirect arriving together with an ack
  // squashes that ack and restarts straight at the new target.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    target_d     = target_q;
    squash_d     = squash_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) fetch_addr_d = redirect_pc;
        if (fetch_start)    state_d      = REQ;
      end
      REQ: begin
        if (mem_ack) begin
          if (squash_q || redirect_valid) begin
            fetch_addr_d = redirect_valid ? redirect_pc : target_q;
            squash_d     = 1'b0;
            state_d      = REQ;
          end else begin
            ir_d         = mem_rdata;
            pc_d         = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + PC_STEP;
            state_d      = DONE;
          end
        end else begin
          if (redirect_valid) begin
            squash_d = 1'b1;
            target_d = redirect_pc;
          end
`ifdef FETCH_TIMEOUT_EN
          if (wd_expired) state_d = FAULT;
`endif
        end
      end
      DONE: begin
        if (redirect_valid) fetch_addr_d = redirect_pc;
        state_d = IDLE;
      end
`ifdef FETCH_TIMEOUT_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      ir_q         <= '0;
      pc_q         <= RESET_PC;
      target_q     <= RESET_PC;
      squash_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      squash_q     <= squash_d;
    end
  end

  assign mem_req  = (state_q == REQ);
  assign mem_addr = fetch_addr_q;
  assign ir       = ir_q;
  assign pc       = pc_q;
  assign ir_valid = (state_q == DONE);
  assign busy     = (state_q != IDLE);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = (state_q == FAULT);
`else
  assign fetch_fault = 1'b0 & wd_expired;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized fetches
// against a transaction-level model (next address, ir, pc).
// Define FETCH_TIMEOUT_EN to exercise the timeout fault path.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        nRst = 1'b0;
  logic        fetch_start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req, ir_valid, busy, fetch_fault;
  logic [31:0] mem_addr, ir, pc;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_next, m_ir, m_pc;

  always #5 clock = ~clock;

  instruction_fetch #(
    .RESET_PC       (32'h0),
    .PC_STEP        (32'h1),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clock          (clock),
    .nRst           (nRst),
    .fetch_start    (fetch_start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .ir             (ir),
    .ir_valid       (ir_valid),
    .pc             (pc),
    .busy           (busy),
    .fetch_fault    (fetch_fault)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete fetch from IDLE; reports what was observed, checks nothing.
  task automatic do_fetch(input logic [31:0] rdata, input int delay, input bit hold_start,
                          output logic [31:0] addr_seen, output int req_cycles,
                          output bit stable, output int valid_cycle,
                          output int valid_cycles, output bit idle_ok);
    fetch_start = 1'b1;
    tick();
    if (!hold_start) fetch_start = 1'b0;
    addr_seen = mem_addr;
    req_cycles = 0;
    stable = 1'b1;
    valid_cycle = 0;
    valid_cycles = 0;
    idle_ok = 1'b1;
    for (int i = 0; i <= delay; i++) begin
      if (mem_req) req_cycles++;
      if (mem_addr !== addr_seen || ir_valid) stable = 1'b0;
      if (i == delay) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    for (int c = 0; c < 3; c++) begin
      if (ir_valid) begin
        valid_cycles++;
        if (valid_cycle == 0) valid_cycle = delay + 3 + c;
      end
      if (c > 0 && (mem_req || busy)) idle_ok = 1'b0;
      if (c < 2) tick();
      fetch_start = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_next = 32'h0;
    m_ir = 32'h0;
    m_pc = 32'h0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    #1;
    model_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", ir); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_fetch_addr: got %h want 0", mem_addr); end
    checks++; if ({ir_valid, busy, fetch_fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ir_valid, busy, fetch_fault}); end
    repeat (2) @(posedge clock);
    #1 nRst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir !== 32'h0 || ir_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got ir=%h v=%b busy=%b want ir=0 v=0 busy=0", ir, ir_valid, busy); end
  endtask

  task automatic test_basic();
    logic [31:0] a; int rc, vc, vn; bit st, ok;
    do_fetch(32'h1A2B3C4D, 0, 1'b0, a, rc, st, vc, vn, ok);
    checks++; if (a !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h want 0", a); end
    checks++; if (ir !== 32'h1A2B3C4D) begin errors++; $display("FAIL basic_ir: got %h want 1a2b3c4d", ir); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h want 0", pc); end
    checks++; if (vc !== 3 || vn !== 1) begin errors++; $display("FAIL basic_latency: got cycle=%0d pulses=%0d want cycle=3 pulses=1", vc, vn); end
    m_ir = 32'h1A2B3C4D; m_pc = 32'h0; m_next = 32'h1;
    checks++; if (mem_addr !== m_next) begin errors++; $display("FAIL basic_next_addr: got %h want %h", mem_addr, m_next); end
  endtask

  task automatic test_delayed_ack();
    logic [31:0] a; int rc, vc, vn; bit st, ok;
    logic [31:0] d = 32'hC0DE_0005;
    do_fetch(d, 4, 1'b1, a, rc, st, vc, vn, ok);
    checks++; if (rc !== 5 || st !== 1'b1) begin errors++; $display("FAIL delayed_req_hold: got cycles=%0d stable=%b want cycles=5 stable=1", rc, st); end
    checks++; if (a !== m_next) begin errors++; $display("FAIL delayed_addr: got %h want %h", a, m_next); end
    checks++; if (vn !== 1 || vc !== 7) begin errors++; $display("FAIL delayed_valid: got pulses=%0d cycle=%0d want pulses=1 cycle=7", vn, vc); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL start_ignored_when_busy: got idle_ok=%b want 1", ok); end
    m_ir = d; m_pc = m_next; m_next = m_next + 32'h1;
    checks++; if (ir !== m_ir || pc !== m_pc) begin errors++; $display("FAIL delayed_latch: got ir=%h pc=%h want ir=%h pc=%h", ir, pc, m_ir, m_pc); end
  endtask

  task automatic test_redirect_in_req();
    logic [31:0] d = $urandom;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    redirect_pc = $urandom;
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir !== m_ir || ir_valid !== 1'b0 || pc !== m_pc) begin errors++; $display("FAIL squash_unchanged: got ir=%h v=%b pc=%h want ir=%h v=0 pc=%h", ir, ir_valid, pc, m_ir, m_pc); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL squash_reissue: got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr); end
    mem_ack = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack = 1'b0;
    m_ir = d; m_pc = 32'h40; m_next = 32'h41;
    checks++; if (ir_valid !== 1'b1 || ir !== m_ir || pc !== m_pc) begin errors++; $display("FAIL redirect_latch: got v=%b ir=%h pc=%h want v=1 ir=%h pc=%h", ir_valid, ir, pc, m_ir, m_pc); end
    tick();
  endtask

  task automatic test_redirect_idle_and_wrap();
    logic [31:0] a; int rc, vc, vn; bit st, ok;
    logic [31:0] d = $urandom;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    fetch_start = 1'b1;
    tick();
    redirect_valid = 1'b0;
    fetch_start = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL idle_redirect_addr: got req=%b addr=%h want req=1 addr=80", mem_req, mem_addr); end
    mem_ack = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack = 1'b0;
    tick();
    m_ir = d; m_pc = 32'h80; m_next = 32'h81;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    m_next = 32'hFFFF_FFFF;
    d = $urandom;
    do_fetch(d, 1, 1'b0, a, rc, st, vc, vn, ok);
    checks++; if (a !== 32'hFFFF_FFFF || pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_top: got addr=%h pc=%h want ffffffff", a, pc); end
    m_ir = d; m_pc = m_next; m_next = m_next + 32'h1;
    d = $urandom;
    do_fetch(d, 0, 1'b0, a, rc, st, vc, vn, ok);
    checks++; if (a !== 32'h0 || pc !== 32'h0 || ir !== d) begin errors++; $display("FAIL wrap_zero: got addr=%h pc=%h ir=%h want 0 0 %h", a, pc, ir, d); end
    m_ir = d; m_pc = 32'h0; m_next = 32'h1;
  endtask

  task automatic test_random();
    logic [31:0] a, d; int rc, vc, vn, dly; bit st, ok;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
        m_next = redirect_pc;
        tick();
        redirect_valid = 1'b0;
      end
      d = $urandom;
      dly = $urandom_range(0, 5);
      do_fetch(d, dly, 1'b0, a, rc, st, vc, vn, ok);
      checks++; if (a !== m_next || rc !== dly + 1) begin errors++; $display("FAIL rand_req[%0d]: got addr=%h cycles=%0d want addr=%h cycles=%0d", n, a, rc, m_next, dly + 1); end
      m_ir = d; m_pc = m_next; m_next = m_next + 32'h1;
      checks++; if (ir !== m_ir || pc !== m_pc || vn !== 1) begin errors++; $display("FAIL rand_latch[%0d]: got ir=%h pc=%h pulses=%0d want ir=%h pc=%h pulses=1", n, ir, pc, vn, m_ir, m_pc); end
    end
  endtask

  task automatic test_reset_mid_req();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    nRst = 1'b0;
    #1;
    model_reset();
    checks++; if ({mem_req, ir_valid, busy, fetch_fault} !== 4'b0000 || ir !== 32'h0 || pc !== 32'h0) begin errors++; $display("FAIL reset_mid_req: got req=%b v=%b busy=%b flt=%b ir=%h pc=%h want all 0", mem_req, ir_valid, busy, fetch_fault, ir, pc); end
    tick();
    nRst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    tick();
    mem_ack = 1'b0;
    tick();
    checks++; if (ir !== m_ir || ir_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== m_next) begin errors++; $display("FAIL late_ack_ignored: got ir=%h v=%b req=%b addr=%h want ir=0 v=0 req=0 addr=0", ir, ir_valid, mem_req, mem_addr); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", n); end
    checks++; if ({fetch_fault, busy, mem_req} !== 3'b110) begin errors++; $display("FAIL timeout_fault: got flt/busy/req=%b want 110", {fetch_fault, busy, mem_req}); end
    fetch_start = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1234;
    mem_ack = 1'b1;
    repeat (4) tick();
    fetch_start = 1'b0;
    redirect_valid = 1'b0;
    mem_ack = 1'b0;
    checks++; if ({fetch_fault, mem_req} !== 2'b10 || ir !== m_ir) begin errors++; $display("FAIL fault_sticky: got flt=%b req=%b ir=%h want 1 0 %h", fetch_fault, mem_req, ir, m_ir); end
    nRst = 1'b0;
    #1;
    checks++; if ({fetch_fault, busy} !== 2'b00) begin errors++; $display("FAIL fault_reset: got flt=%b busy=%b want 0 0", fetch_fault, busy); end
    tick();
    nRst = 1'b1;
    model_reset();
  endtask
`else
  task automatic test_no_timeout();
    logic [31:0] a, d; int rc, vc, vn; bit st, ok;
    d = $urandom;
    do_fetch(d, 20, 1'b0, a, rc, st, vc, vn, ok);
    checks++; if (rc !== 21 || fetch_fault !== 1'b0 || ir !== d || pc !== m_next) begin errors++; $display("FAIL long_wait: got cycles=%0d flt=%b ir=%h pc=%h want 21 0 %h %h", rc, fetch_fault, ir, pc, d, m_next); end
    m_ir = d; m_pc = m_next; m_next = m_next + 32'h1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_redirect_in_req();
    test_redirect_idle_and_wrap();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
